// File: rtl/move_input_ctrl.sv
// ---------------------------------------------------------------------------
// move_input_ctrl
//
// Turns the four raw movement buttons of the Go board into clean, one-at-a-time
// move requests for the raccoon controller. Each button is synchronised and
// debounced. A fresh press issues one request. Holding the button auto-repeats,
// first after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles. Requests
// leave through a one-deep valid/ready handshake, and only while i_Enable is high.
//
// Ports
//   i_Clk         system clock (25 MHz)
//   i_Rst_n       asynchronous active-low reset (release is re-synchronised)
//   i_Switch_Up   raw up button, asynchronous, active-high
//   i_Switch_Dn   raw down button, asynchronous, active-high
//   i_Switch_Lt   raw left button, asynchronous, active-high
//   i_Switch_Rt   raw right button, asynchronous, active-high
//   i_Enable      1 = game in RUN; 0 = suppress and flush move requests
//   i_Move_Ready  consumer accepts the pending request this cycle
//   o_Move_Valid  move request pending
//   o_Move_Dir    request direction: 00 up, 01 down, 10 left, 11 right
//   o_Buttons_Db  debounced button levels {Rt,Lt,Dn,Up}
// ---------------------------------------------------------------------------
module move_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Dn,
  input  logic       i_Switch_Lt,
  input  logic       i_Switch_Rt,
  input  logic       i_Enable,
  input  logic       i_Move_Ready,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic [3:0] o_Buttons_Db
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // -------------------------------------------------------------------------
  // Reset: asserted asynchronously, released on a clock edge so that no flop
  // sees the release edge close to its clock.
  // -------------------------------------------------------------------------
  logic rst_meta_q;
  logic rst_sync_n_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Synchronisers and debounce
  // -------------------------------------------------------------------------
  logic [3:0] sw_raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] db_q;
  logic [3:0] db_d;
  logic [3:0] db_prev_q;

  assign sw_raw = {i_Switch_Rt, i_Switch_Lt, i_Switch_Dn, i_Switch_Up};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            lvl_d;

      // The counter only runs while the synced input disagrees with the
      // debounced level; any agreement restarts the qualification window.
      always_comb begin
        cnt_d = '0;
        lvl_d = db_q[gi];
        if (sync2_q[gi] != db_q[gi]) begin
          if (cnt_q == DB_LAST) begin
            lvl_d = ~db_q[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge i_Clk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign db_d[gi] = lvl_d;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Press detection with fixed priority Up > Dn > Lt > Rt
  // -------------------------------------------------------------------------
  logic [3:0] press;
  logic       press_any;
  logic [1:0] press_dir;

  assign press     = db_q & ~db_prev_q;
  assign press_any = |press;

  always_comb begin
    press_dir = 2'd3;
    if (press[0]) begin
      press_dir = 2'd0;
    end else if (press[1]) begin
      press_dir = 2'd1;
    end else if (press[2]) begin
      press_dir = 2'd2;
    end
  end

  // -------------------------------------------------------------------------
  // Auto-repeat FSM
  // -------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [1:0]       held_dir_q;
  logic [1:0]       held_dir_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             held_level;
  logic             issue;

  assign held_level = db_q[held_dir_q];

  always_comb begin
    state_d    = state_q;
    held_dir_d = held_dir_q;
    timer_d    = timer_q;
    issue      = 1'b0;
    if (!i_Enable) begin
      // Leaving RUN forgets the held button; only a fresh press restarts.
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_any) begin
            held_dir_d = press_dir;
            issue      = 1'b1;
            timer_d    = DELAY_LOAD;
            state_d    = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!held_level) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == '0) begin
            issue   = 1'b1;
            timer_d = PERIOD_LOAD;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!held_level) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == '0) begin
            issue   = 1'b1;
            timer_d = PERIOD_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // One-deep request register. An issue arriving while a request is still
  // pending (even one being accepted this cycle) is dropped, not queued.
  // -------------------------------------------------------------------------
  logic       valid_q;
  logic       valid_d;
  logic [1:0] dir_q;
  logic [1:0] dir_d;

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    if (!i_Enable) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (i_Move_Ready) begin
        valid_d = 1'b0;
      end
    end else if (issue) begin
      valid_d = 1'b1;
      dir_d   = held_dir_d;
    end
  end

  always_ff @(posedge i_Clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      state_q    <= ST_IDLE;
      held_dir_q <= 2'd0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 2'd0;
    end else begin
      sync1_q    <= sw_raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      state_q    <= state_d;
      held_dir_q <= held_dir_d;
      timer_q    <= timer_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
    end
  end

  assign o_Move_Valid = valid_q;
  assign o_Move_Dir   = dir_q;
  assign o_Buttons_Db = db_q;

endmodule
